// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register-access command (device, register, 1-2 data bytes, read/write)
// into the start/stop/wr_data handshake of the byte-level I2C master core and collects read bytes.
module i2c_reg_seq #(
  parameter int STOP_WAIT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic        len2,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        core_start,
  output logic        core_stop,
  output logic [7:0]  core_wr_data,
  input  logic [1:0]  core_ack,
  input  logic        core_rd_tick,
  input  logic [7:0]  core_rd_data
);

  localparam int CW = (STOP_WAIT_CYC > 1) ? $clog2(STOP_WAIT_CYC) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(STOP_WAIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, START, W_DEV, W_REG, W_DAT, W_RDEV, RD, STOPW, DONE
  } state_t;

  state_t state, state_nxt;

  logic          rw_q;
  logic          len2_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [15:0]   wdata_q;
  logic          bcnt;
  logic [CW-1:0] wait_cnt;

  logic ack_tick;
  logic ack_ok;
  logic nack;
  logic last;

  assign ack_tick = core_ack[1];
  assign ack_ok   = core_ack[0];
  assign nack     = ack_tick & ~ack_ok;
  assign last     = (bcnt == len2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (req) state_nxt = START;
      START:  state_nxt = W_DEV;
      W_DEV:  if (ack_tick) state_nxt = ack_ok ? W_REG : STOPW;
      W_REG:  if (ack_tick) state_nxt = !ack_ok ? STOPW : (rw_q ? W_RDEV : W_DAT);
      W_DAT:  if (ack_tick && (!ack_ok || last)) state_nxt = STOPW;
      W_RDEV: if (ack_tick) state_nxt = ack_ok ? RD : STOPW;
      RD:     if (core_rd_tick && last) state_nxt = STOPW;
      STOPW:  if (wait_cnt == '0) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A NACK tick raises stop combinationally so the core ends the transfer on that same tick.
  always_comb begin
    core_start   = 1'b0;
    core_stop    = 1'b0;
    core_wr_data = 8'h00;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      START: begin
        core_start   = 1'b1;
        core_wr_data = {dev_q, 1'b0};
      end
      W_DEV: begin
        core_wr_data = {dev_q, 1'b0};
        core_stop    = nack;
      end
      W_REG: begin
        core_wr_data = reg_q;
        core_start   = rw_q;
        core_stop    = nack;
      end
      W_DAT: begin
        core_wr_data = (len2_q && !bcnt) ? wdata_q[15:8] : wdata_q[7:0];
        core_stop    = last | nack;
      end
      W_RDEV: begin
        core_wr_data = {dev_q, 1'b1};
        core_stop    = nack;
      end
      RD:    core_stop = last;
      STOPW: ;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q     <= 1'b0;
      len2_q   <= 1'b0;
      dev_q    <= 7'h00;
      reg_q    <= 8'h00;
      wdata_q  <= 16'h0000;
      bcnt     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 16'h0000;
      wait_cnt <= '0;
    end else begin
      if (state != STOPW)        wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)   wait_cnt <= wait_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (req) begin
            rw_q    <= rw;
            len2_q  <= len2;
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            wdata_q <= wdata;
            bcnt    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 16'h0000;
          end
        end
        W_DEV, W_REG: begin
          if (nack) err <= 1'b1;
        end
        W_RDEV: begin
          if (nack)                   err  <= 1'b1;
          else if (ack_tick && ack_ok) bcnt <= 1'b0;
        end
        W_DAT: begin
          if (ack_tick) begin
            if (!ack_ok)    err  <= 1'b1;
            else if (!last) bcnt <= bcnt + 1'b1;
          end
        end
        // First byte of a two-byte read is the MSB.
        RD: begin
          if (core_rd_tick) begin
            if (len2_q && !bcnt) rdata[15:8] <= core_rd_data;
            else                 rdata[7:0]  <= core_rd_data;
            if (!last) bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: a behavioural core model consumes expected bytes from a
// scoreboard queue, and a done monitor compares err/rdata/latency against a result queue.
module tb_i2c_reg_seq;

  localparam int SW       = 16;
  localparam int BYTE_CYC = 4;
  localparam int MAX_WAIT = 300 + SW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [6:0]  dev_addr = 7'h00;
  logic [7:0]  reg_addr = 8'h00;
  logic        len2 = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        core_start, core_stop;
  logic [7:0]  core_wr_data;
  logic [1:0]  core_ack;
  logic        core_rd_tick;
  logic [7:0]  core_rd_data;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    bit         ack;
    bit         stop_pre;
    bit         stop_tick;
    bit         start_tick;
  } byte_exp_t;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
  } res_exp_t;

  byte_exp_t exp_q[$];
  res_exp_t  res_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_tick_cyc = 0;
  int bytes_seen = 0;

  i2c_reg_seq #(.STOP_WAIT_CYC(SW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .len2(len2), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .core_start(core_start), .core_stop(core_stop), .core_wr_data(core_wr_data),
    .core_ack(core_ack), .core_rd_tick(core_rd_tick), .core_rd_data(core_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_w(input logic [7:0] d, input bit ack, input bit pre, input bit tick, input bit st);
    byte_exp_t e;
    e.is_rd = 1'b0; e.data = d; e.ack = ack; e.stop_pre = pre; e.stop_tick = tick; e.start_tick = st;
    exp_q.push_back(e);
  endtask

  task automatic push_r(input logic [7:0] d, input bit last);
    byte_exp_t e;
    e.is_rd = 1'b1; e.data = d; e.ack = 1'b1; e.stop_pre = last; e.stop_tick = last; e.start_tick = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_res(input logic e, input logic [15:0] r);
    res_exp_t x;
    x.err = e; x.rdata = r;
    res_q.push_back(x);
  endtask

  // Inputs are scrambled right after the accept cycle so the command must have been latched.
  task automatic drive_cmd(input bit r, input logic [6:0] d, input logic [7:0] ra, input bit l2, input logic [15:0] wd);
    @(negedge clk);
    rw = r; dev_addr = d; reg_addr = ra; len2 = l2; wdata = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rw = ~r; dev_addr = ~d; reg_addr = ~ra; len2 = ~l2; wdata = ~wd;
  endtask

  task automatic run_until_done(output bit timed_out);
    int start;
    start = done_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk); #2;
      if (done_cnt != start) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Behavioural byte-level core: checks each written byte and the stop/start it sees, answers ticks.
  initial begin : core_model
    byte_exp_t  e;
    logic [7:0] cur;
    bit         ab;
    core_ack = 2'b00; core_rd_tick = 1'b0; core_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        cur = core_wr_data;
        ab = 1'b0;
        while (!ab) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("[TB] FAIL core_unexpected_byte: got %h, required no byte", cur);
            break;
          end
          e = exp_q.pop_front();
          bytes_seen++;
          if (!e.is_rd) begin
            n_chk++;
            if (cur !== e.data) begin n_fail++; $display("[TB] FAIL wr_byte: got %h, required %h", cur, e.data); end
          end
          for (int i = 0; i < BYTE_CYC - 1; i++) begin
            @(negedge clk);
            if (!rst_n) begin ab = 1'b1; break; end
          end
          if (ab) break;
          n_chk++;
          if (core_stop !== e.stop_pre) begin n_fail++; $display("[TB] FAIL stop_in_byte %h: got %b, required %b", e.data, core_stop, e.stop_pre); end
          @(negedge clk);
          if (!rst_n) break;
          if (e.is_rd) begin core_rd_tick = 1'b1; core_rd_data = e.data; end
          else core_ack = {1'b1, e.ack};
          #1;
          n_chk++;
          if (core_stop !== e.stop_tick) begin n_fail++; $display("[TB] FAIL stop_at_tick %h: got %b, required %b", e.data, core_stop, e.stop_tick); end
          if (!e.is_rd) begin
            n_chk++;
            if (core_start !== e.start_tick) begin n_fail++; $display("[TB] FAIL start_at_tick %h: got %b, required %b", e.data, core_start, e.start_tick); end
          end
          last_tick_cyc = cyc;
          @(negedge clk);
          core_ack = 2'b00; core_rd_tick = 1'b0; core_rd_data = 8'h00;
          if (!rst_n || e.stop_tick) break;
          cur = core_wr_data;
        end
        core_ack = 2'b00; core_rd_tick = 1'b0; core_rd_data = 8'h00;
      end
    end
  end

  initial begin : done_monitor
    res_exp_t r;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_done = 1'b0;
      else begin
        if (done) begin
          done_cnt++;
          n_chk++;
          if (prev_done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_pulse_width: got %b, required 0 before done", prev_done); end
          if (res_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("[TB] FAIL unexpected_done: got done, required no transaction");
          end else begin
            r = res_q.pop_front();
            n_chk += 4;
            if (err !== r.err) begin n_fail++; $display("[TB] FAIL err: got %b, required %b", err, r.err); end
            if (rdata !== r.rdata) begin n_fail++; $display("[TB] FAIL rdata: got %h, required %h", rdata, r.rdata); end
            if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_at_done: got %b, required 0", busy); end
            if (cyc !== last_tick_cyc + SW + 1) begin n_fail++; $display("[TB] FAIL stop_wait: got %0d, required %0d", cyc - last_tick_cyc, SW + 1); end
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk += 3;
    if ({busy, done, err, core_start, core_stop} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b, required 00000", {busy, done, err, core_start, core_stop}); end
    if (rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h, required 0000", rdata); end
    if (core_wr_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_wr_data: got %h, required 00", core_wr_data); end
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_write1();
    bit to;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h10, 1, 0, 0, 0); push_w(8'hA5, 1, 1, 1, 0);
    push_res(1'b0, 16'h0000);
    drive_cmd(1'b0, 7'h48, 8'h10, 1'b0, 16'h00A5);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL write1_busy: got %b, required 1", busy); end
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL write1_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL write1_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_write2();
    bit to;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h10, 1, 0, 0, 0);
    push_w(8'h12, 1, 0, 0, 0); push_w(8'h34, 1, 1, 1, 0);
    push_res(1'b0, 16'h0000);
    drive_cmd(1'b0, 7'h48, 8'h10, 1'b1, 16'h1234);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL write2_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL write2_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_read2();
    bit to;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h02, 1, 0, 0, 1); push_w(8'h91, 1, 0, 0, 0);
    push_r(8'hBE, 0); push_r(8'hEF, 1);
    push_res(1'b0, 16'hBEEF);
    drive_cmd(1'b1, 7'h48, 8'h02, 1'b1, 16'h0000);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL read2_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL read2_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_read1();
    bit to;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h05, 1, 0, 0, 1); push_w(8'h91, 1, 0, 0, 0);
    push_r(8'h5A, 1);
    push_res(1'b0, 16'h005A);
    drive_cmd(1'b1, 7'h48, 8'h05, 1'b0, 16'hFFFF);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL read1_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL read1_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_addr_nack();
    bit to;
    push_w(8'h78, 0, 0, 1, 0);
    push_res(1'b1, 16'h0000);
    drive_cmd(1'b0, 7'h3C, 8'h10, 1'b0, 16'h0055);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL addr_nack_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL addr_nack_bytes_left: got %0d, required 0", exp_q.size()); end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_held: got %b, required 1", err); end
  endtask

  task automatic test_data_nack();
    bit to;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h10, 1, 0, 0, 0); push_w(8'h12, 0, 0, 1, 0);
    push_res(1'b1, 16'h0000);
    drive_cmd(1'b0, 7'h48, 8'h10, 1'b1, 16'h1234);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL data_nack_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL data_nack_bytes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to;
    bit got;
    int base;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h20, 1, 0, 0, 0); push_w(8'h11, 1, 1, 1, 0);
    push_res(1'b0, 16'h0000);
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h21, 1, 0, 0, 0); push_w(8'h22, 1, 1, 1, 0);
    push_res(1'b0, 16'h0000);
    base = done_cnt;
    drive_cmd(1'b0, 7'h48, 8'h20, 1'b0, 16'h0011);
    repeat (3) @(negedge clk);
    rw = 1'b0; dev_addr = 7'h48; reg_addr = 8'h30; len2 = 1'b1; wdata = 16'hDEAD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    reg_addr = 8'h21; len2 = 1'b0; wdata = 16'h0022; req = 1'b1;
    run_until_done(to);
    n_chk++;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_first_timeout: got timeout, required done"); end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (busy) begin got = 1'b1; break; end
    end
    req = 1'b0;
    n_chk++;
    if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_reaccept: got %b, required 1", got); end
    run_until_done(to);
    n_chk++;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_timeout: got timeout, required done"); end
    repeat (10) @(negedge clk);
    n_chk += 3;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_after: got %b, required 0", busy); end
    if (done_cnt - base !== 2) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d, required 2", done_cnt - base); end
    if (exp_q.size() + res_q.size() !== 0) begin n_fail++; $display("[TB] FAIL b2b_left: got %0d, required 0", exp_q.size() + res_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit to;
    bit got;
    int base;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h02, 1, 0, 0, 1); push_w(8'h91, 1, 0, 0, 0);
    push_r(8'hC3, 0); push_r(8'h3C, 1);
    base = bytes_seen;
    drive_cmd(1'b1, 7'h48, 8'h02, 1'b1, 16'h0000);
    got = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk); #2;
      if (bytes_seen - base >= 4) begin got = 1'b1; break; end
    end
    n_chk++;
    if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_reach_rd: got %b, required 1", got); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    n_chk += 3;
    if ({busy, done, err, core_start, core_stop} !== 5'b0) begin n_fail++; $display("[TB] FAIL rst_mid_ctrl: got %b, required 00000", {busy, done, err, core_start, core_stop}); end
    if (rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_mid_rdata: got %h, required 0000", rdata); end
    if (core_wr_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_mid_wr_data: got %h, required 00", core_wr_data); end
    repeat (3) @(negedge clk);
    exp_q.delete();
    res_q.delete();
    #2 rst_n = 1'b1;
    push_w(8'h90, 1, 0, 0, 0); push_w(8'h10, 1, 0, 0, 0); push_w(8'hA5, 1, 1, 1, 0);
    push_res(1'b0, 16'h0000);
    drive_cmd(1'b0, 7'h48, 8'h10, 1'b0, 16'h00A5);
    run_until_done(to);
    n_chk += 2;
    if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_recover_timeout: got timeout, required done"); end
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_recover_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    $display("[TB] starting i2c_reg_seq bench");
    test_reset();
    test_write1();
    test_write2();
    test_read2();
    test_read1();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_reset_mid_read();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
